// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode values, class bit positions and per-opcode register usage.
package decode_pkg;

  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_ADD  = 1;
  localparam int unsigned OP_ADDI = 2;
  localparam int unsigned OP_SUB  = 3;
  localparam int unsigned OP_MULT = 5;
  localparam int unsigned OP_DIV  = 7;
  localparam int unsigned OP_LR   = 8;
  localparam int unsigned OP_SR   = 9;
  localparam int unsigned OP_BLEQ = 13;
  localparam int unsigned OP_AND  = 14;
  localparam int unsigned OP_BEQ  = 18;
  localparam int unsigned OP_BNEQ = 19;
  localparam int unsigned OP_BGEQ = 22;
  localparam int unsigned OP_BGT  = 23;
  localparam int unsigned OP_MOV  = 27;

  localparam int unsigned CLS_ALU    = 0;
  localparam int unsigned CLS_LOAD   = 1;
  localparam int unsigned CLS_STORE  = 2;
  localparam int unsigned CLS_BRANCH = 3;
  localparam int unsigned CLS_WIDTH  = 4;

  // Port A reads rs (or rd when src_a_sel); port B reads rn (or rs when src_a_sel).
  typedef struct packed {
    logic reads_a;
    logic reads_b;
    logic src_a_sel;
    logic writes;
  } reg_usage_t;

  function automatic reg_usage_t op_usage(input int unsigned op);
    reg_usage_t u;
    u = '0;
    case (op)
      OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_AND: begin
        u.reads_a = 1'b1;
        u.reads_b = 1'b1;
        u.writes  = 1'b1;
      end
      OP_ADDI, OP_LR, OP_MOV: begin
        u.reads_a = 1'b1;
        u.writes  = 1'b1;
      end
      OP_SR: begin
        u.reads_a   = 1'b1;
        u.reads_b   = 1'b1;
        u.src_a_sel = 1'b1;
      end
      OP_BLEQ, OP_BEQ, OP_BNEQ, OP_BGEQ, OP_BGT: begin
        u.reads_a = 1'b1;
        u.reads_b = 1'b1;
      end
      default: u = '0;
    endcase
    return u;
  endfunction

  function automatic logic [CLS_WIDTH-1:0] op_class(input int unsigned op);
    logic [CLS_WIDTH-1:0] c;
    c = '0;
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_MULT, OP_DIV, OP_AND, OP_MOV: c[CLS_ALU] = 1'b1;
      OP_LR:                                                    c[CLS_LOAD] = 1'b1;
      OP_SR:                                                    c[CLS_STORE] = 1'b1;
      OP_BLEQ, OP_BEQ, OP_BNEQ, OP_BGEQ, OP_BGT:                c[CLS_BRANCH] = 1'b1;
      default:                                                  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic op_defined(input int unsigned op);
    logic d;
    case (op)
      OP_NOP, OP_ADD, OP_ADDI, OP_SUB, OP_MULT, OP_DIV, OP_LR, OP_SR, OP_BLEQ, OP_AND,
      OP_BEQ, OP_BNEQ, OP_BGEQ, OP_BGT, OP_MOV: d = 1'b1;
      default:                                  d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode stage bundle: fetch handshake, decoded output handshake, writeback report and flush.
interface decode_stage_if #(
  parameter int unsigned INSTRUCTION_WIDTH = 19,
  parameter int unsigned WIDTH_OPCODE      = 5,
  parameter int unsigned REGFILE_ADDR_BITS = 2,
  parameter int unsigned DATA_WIDTH        = 16
) ();

  logic                             in_valid;
  logic                             in_ready;
  logic [INSTRUCTION_WIDTH-1:0]     in_instr;

  logic                             out_valid;
  logic                             out_ready;
  logic [WIDTH_OPCODE-1:0]          out_opcode;
  logic [REGFILE_ADDR_BITS-1:0]     out_rd;
  logic [REGFILE_ADDR_BITS-1:0]     out_rs;
  logic [REGFILE_ADDR_BITS-1:0]     out_rn;
  logic [DATA_WIDTH-1:0]            out_imm;
  logic [decode_pkg::CLS_WIDTH-1:0] out_class;
  logic                             out_writes_reg;
  logic                             out_illegal;

  logic                             wb_valid;
  logic [REGFILE_ADDR_BITS-1:0]     wb_reg;
  logic                             flush;

  // Environment side: fetch, downstream consumer and writeback.
  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_reg, flush,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rn, out_imm, out_class,
           out_writes_reg, out_illegal
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_reg, flush,
    output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rn, out_imm, out_class,
           out_writes_reg, out_illegal
  );

endinterface

// File: rtl/decode_scoreboard.sv
// Pending-write bitmap for RAW/WAW stalls; a writeback clear is bypassed into the same-cycle query.
module decode_scoreboard #(
  parameter int unsigned REGFILE_ADDR_BITS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         set_en,
  input  logic [REGFILE_ADDR_BITS-1:0] set_reg,
  input  logic                         clr_en,
  input  logic [REGFILE_ADDR_BITS-1:0] clr_reg,
  input  logic                         squash_en,
  input  logic [REGFILE_ADDR_BITS-1:0] squash_reg,
  input  logic                         read_a_en,
  input  logic [REGFILE_ADDR_BITS-1:0] read_a_reg,
  input  logic                         read_b_en,
  input  logic [REGFILE_ADDR_BITS-1:0] read_b_reg,
  input  logic                         write_en,
  input  logic [REGFILE_ADDR_BITS-1:0] write_reg,
  output logic                         hazard
);

  localparam int unsigned NUM_REGS = 2 ** REGFILE_ADDR_BITS;

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] visible;

  always_comb begin
    visible = pending_q;
    if (clr_en) visible[clr_reg] = 1'b0;
  end

  assign hazard = (read_a_en & visible[read_a_reg]) |
                  (read_b_en & visible[read_b_reg]) |
                  (write_en  & visible[write_reg]);

  // Set is applied last so it wins over a same-cycle clear of the same register.
  always_comb begin
    pending_d = visible;
    if (squash_en) pending_d[squash_reg] = 1'b0;
    if (set_en)    pending_d[set_reg]    = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered handshaked instruction decode with scoreboard stalls.
// Optional: define DECODE_ILLEGAL_TRAP_EN to flag undefined opcodes and halt until flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = 19,
  parameter int unsigned WIDTH_OPCODE      = 5,
  parameter int unsigned REGFILE_ADDR_BITS = 2,
  parameter int unsigned IMMEDIATE_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH        = 16
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  localparam int unsigned RD_LSB = INSTRUCTION_WIDTH - WIDTH_OPCODE - REGFILE_ADDR_BITS;
  localparam int unsigned RS_LSB = RD_LSB - REGFILE_ADDR_BITS;
  localparam int unsigned RN_LSB = RS_LSB - REGFILE_ADDR_BITS;

  logic [WIDTH_OPCODE-1:0]      opcode;
  logic [REGFILE_ADDR_BITS-1:0] rd;
  logic [REGFILE_ADDR_BITS-1:0] rs;
  logic [REGFILE_ADDR_BITS-1:0] rn;
  logic [IMMEDIATE_WIDTH-1:0]   imm;
  logic [DATA_WIDTH-1:0]        imm_ext;
  reg_usage_t                   usage;
  logic [CLS_WIDTH-1:0]         cls;
  logic                         writes;
  logic                         hazard;
  logic                         halted;
  logic                         ready;
  logic                         accept;

  assign opcode = bus.in_instr[INSTRUCTION_WIDTH-1 -: WIDTH_OPCODE];
  assign rd     = bus.in_instr[RD_LSB +: REGFILE_ADDR_BITS];
  assign rs     = bus.in_instr[RS_LSB +: REGFILE_ADDR_BITS];
  assign rn     = bus.in_instr[RN_LSB +: REGFILE_ADDR_BITS];
  assign imm    = bus.in_instr[IMMEDIATE_WIDTH-1:0];

  always_comb begin
    imm_ext = {DATA_WIDTH{imm[IMMEDIATE_WIDTH-1]}};
    imm_ext[IMMEDIATE_WIDTH-1:0] = imm;
  end

  assign usage  = op_usage(32'(opcode));
  assign cls    = op_class(32'(opcode));
  assign writes = usage.writes & (rd != '0);

  // Output register state.
  logic                         out_valid_q;
  logic                         out_valid_d;
  logic [WIDTH_OPCODE-1:0]      opcode_q;
  logic [REGFILE_ADDR_BITS-1:0] rd_q;
  logic [REGFILE_ADDR_BITS-1:0] rs_q;
  logic [REGFILE_ADDR_BITS-1:0] rn_q;
  logic [DATA_WIDTH-1:0]        imm_q;
  logic [CLS_WIDTH-1:0]         class_q;
  logic                         writes_q;

  assign ready  = rst_n & (~out_valid_q | bus.out_ready) & ~hazard & ~halted & ~bus.flush;
  assign accept = bus.in_valid & ready;

  decode_scoreboard #(
    .REGFILE_ADDR_BITS (REGFILE_ADDR_BITS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (accept & writes),
    .set_reg    (rd),
    .clr_en     (bus.wb_valid),
    .clr_reg    (bus.wb_reg),
    .squash_en  (bus.flush & out_valid_q & writes_q),
    .squash_reg (rd_q),
    .read_a_en  (usage.reads_a),
    .read_a_reg (usage.src_a_sel ? rd : rs),
    .read_b_en  (usage.reads_b),
    .read_b_reg (usage.src_a_sel ? rs : rn),
    .write_en   (writes),
    .write_reg  (rd),
    .hazard     (hazard)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rn_q        <= '0;
      imm_q       <= '0;
      class_q     <= '0;
      writes_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        opcode_q <= opcode;
        rd_q     <= rd;
        rs_q     <= rs;
        rn_q     <= rn;
        imm_q    <= imm_ext;
        class_q  <= cls;
        writes_q <= writes;
      end
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal;
  logic illegal_q;
  logic halted_q;
  logic halted_d;

  assign illegal = ~op_defined(32'(opcode));

  always_comb begin
    halted_d = halted_q;
    if (bus.flush) begin
      halted_d = 1'b0;
    end else if (accept && illegal) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
      if (accept) illegal_q <= illegal;
    end
  end

  assign halted          = halted_q;
  assign bus.out_illegal = illegal_q;
`else
  assign halted          = 1'b0;
  assign bus.out_illegal = 1'b0;
`endif

  assign bus.in_ready       = ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_opcode     = opcode_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_rs         = rs_q;
  assign bus.out_rn         = rn_q;
  assign bus.out_imm        = imm_q;
  assign bus.out_class      = class_q;
  assign bus.out_writes_reg = writes_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a cycle-level reference model and literal spot checks.
module tb_decode_stage;

  logic clk;
  logic rst_n;

  decode_stage_if #(
    .INSTRUCTION_WIDTH (19),
    .WIDTH_OPCODE      (5),
    .REGFILE_ADDR_BITS (2),
    .DATA_WIDTH        (16)
  ) bus ();

  decode_stage #(
    .INSTRUCTION_WIDTH (19),
    .WIDTH_OPCODE      (5),
    .REGFILE_ADDR_BITS (2),
    .IMMEDIATE_WIDTH   (8),
    .DATA_WIDTH        (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] cls;      // {branch, store, load, alu}
    logic       r_rd;
    logic       r_rs;
    logic       r_rn;
    logic       w_rd;
    logic       illegal;
  } tdec_t;

  function automatic tdec_t tdec(input logic [18:0] ins);
    tdec_t d;
    d = '0;
    case (ins[18:14])
      5'd1, 5'd3, 5'd5, 5'd7, 5'd14: begin d.cls = 4'b0001; d.r_rs = 1; d.r_rn = 1; d.w_rd = 1; end
      5'd2, 5'd27:                   begin d.cls = 4'b0001; d.r_rs = 1; d.w_rd = 1; end
      5'd8:                          begin d.cls = 4'b0010; d.r_rs = 1; d.w_rd = 1; end
      5'd9:                          begin d.cls = 4'b0100; d.r_rd = 1; d.r_rs = 1; end
      5'd13, 5'd18, 5'd19, 5'd22, 5'd23: begin d.cls = 4'b1000; d.r_rs = 1; d.r_rn = 1; end
      5'd0:                          d = '0;
      default:                       d.illegal = 1;
    endcase
    return d;
  endfunction

  function automatic bit tdec_writes(input logic [18:0] ins);
    tdec_t d;
    d = tdec(ins);
    return d.w_rd && (ins[13:12] != 2'd0);
  endfunction

  function automatic bit tdec_illegal(input logic [18:0] ins);
    tdec_t d;
    d = tdec(ins);
`ifdef DECODE_ILLEGAL_TRAP_EN
    return d.illegal;
`else
    return 1'b0;
`endif
  endfunction

  bit          m_valid;
  logic [18:0] m_instr;
  bit          m_pending [4];
  bit          m_halted;

  function automatic bit m_ready();
    tdec_t d;
    bit    vis [4];
    bit    hz;
    d = tdec(bus.in_instr);
    for (int r = 0; r < 4; r++) vis[r] = m_pending[r] && !(bus.wb_valid && int'(bus.wb_reg) == r);
    hz = (d.r_rd && vis[bus.in_instr[13:12]]) || (d.r_rs && vis[bus.in_instr[11:10]]) ||
         (d.r_rn && vis[bus.in_instr[9:8]]) ||
         (tdec_writes(bus.in_instr) && vis[bus.in_instr[13:12]]);
    return rst_n && (!m_valid || bus.out_ready) && !hz && !m_halted && !bus.flush;
  endfunction

  function automatic bit m_pend_next(input int r);
    bit nxt;
    nxt = m_pending[r];
    if (bus.wb_valid && int'(bus.wb_reg) == r) nxt = 0;
    if (bus.flush && m_valid && tdec_writes(m_instr) && int'(m_instr[13:12]) == r) nxt = 0;
    if (bus.in_valid && m_ready() && tdec_writes(bus.in_instr) && int'(bus.in_instr[13:12]) == r)
      nxt = 1;
    if (r == 0) nxt = 0;
    return nxt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 0;
      m_instr  <= '0;
      m_halted <= 0;
      for (int r = 0; r < 4; r++) m_pending[r] <= 0;
    end else begin
      for (int r = 0; r < 4; r++) m_pending[r] <= m_pend_next(r);
      if (bus.flush) begin
        m_valid  <= 0;
        m_halted <= 0;
      end else if (bus.in_valid && m_ready()) begin
        m_valid <= 1;
        m_instr <= bus.in_instr;
        if (tdec_illegal(bus.in_instr)) m_halted <= 1;
      end else if (bus.out_ready) begin
        m_valid <= 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    tdec_t d;
    d = tdec(m_instr);
    cmp("cyc_in_ready", 32'(bus.in_ready), 32'(m_ready()));
    cmp("cyc_out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (!rst_n) begin
      cmp("cyc_rst_fields", 32'({bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rn, bus.out_imm,
                                 bus.out_class, bus.out_writes_reg, bus.out_illegal}), 0);
    end else if (m_valid) begin
      cmp("cyc_opcode", 32'(bus.out_opcode), 32'(m_instr[18:14]));
      cmp("cyc_rd", 32'(bus.out_rd), 32'(m_instr[13:12]));
      cmp("cyc_rs", 32'(bus.out_rs), 32'(m_instr[11:10]));
      cmp("cyc_rn", 32'(bus.out_rn), 32'(m_instr[9:8]));
      cmp("cyc_imm", 32'(bus.out_imm), 32'({{8{m_instr[7]}}, m_instr[7:0]}));
      cmp("cyc_class", 32'(bus.out_class), 32'(d.cls));
      cmp("cyc_writes", 32'(bus.out_writes_reg), 32'(tdec_writes(m_instr)));
      cmp("cyc_illegal", 32'(bus.out_illegal), 32'(tdec_illegal(m_instr)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [18:0] ins);
    bus.in_valid = v;
    bus.in_instr = ins;
  endtask

  task automatic wb(input logic v, input logic [1:0] r);
    bus.wb_valid = v;
    bus.wb_reg   = r;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    drv(1'b1, 19'h21010);
    wb(1'b0, 2'd0);
    step(2); #1;
    cmp("rst_in_ready", 32'(bus.in_ready), 0);
    cmp("rst_out_valid", 32'(bus.out_valid), 0);
    cmp("rst_opcode", 32'(bus.out_opcode), 0);
    cmp("rst_imm", 32'(bus.out_imm), 0);
    cmp("rst_class", 32'(bus.out_class), 0);
    rst_n = 1'b1; #1;
    cmp("post_rst_ready", 32'(bus.in_ready), 1);
    step(1); drv(1'b0, 19'h0); #1;
    cmp("lr_valid", 32'(bus.out_valid), 1);
    cmp("lr_opcode", 32'(bus.out_opcode), 8);
    cmp("lr_rd", 32'(bus.out_rd), 1);
    cmp("lr_imm", 32'(bus.out_imm), 32'h0010);
    cmp("lr_class", 32'(bus.out_class), 32'b0010);
    cmp("lr_writes", 32'(bus.out_writes_reg), 1);
    wb(1'b1, 2'd1); step(1); wb(1'b0, 2'd0);

    // Stream with RAW/WAW stall released by writeback.
    drv(1'b1, 19'h21000); #1; cmp("p2_ready0", 32'(bus.in_ready), 1); step(1);
    drv(1'b1, 19'h22000); #1; cmp("p2_ready1", 32'(bus.in_ready), 1); step(1);
    drv(1'b1, 19'h0B00A); #1; cmp("p2_ready2", 32'(bus.in_ready), 1); step(1);
    drv(1'b1, 19'h05A00); #1; cmp("p2_stall", 32'(bus.in_ready), 0);
    step(2); #1; cmp("p2_stall_hold", 32'(bus.in_ready), 0);
    wb(1'b1, 2'd1); #1; cmp("p2_r2_still_pending", 32'(bus.in_ready), 0);
    step(1);
    wb(1'b1, 2'd2); #1; cmp("p2_wb_bypass", 32'(bus.in_ready), 1);
    step(1); wb(1'b0, 2'd0); drv(1'b0, 19'h0); #1;
    cmp("p2_add_opcode", 32'(bus.out_opcode), 1);
    cmp("p2_add_rs_rn", 32'({bus.out_rs, bus.out_rn}), 32'b1010);
    wb(1'b1, 2'd1); step(1); wb(1'b1, 2'd3); step(1); wb(1'b0, 2'd0);

    // Branch with negative immediate.
    drv(1'b1, 19'h34BFE); #1; cmp("br_ready", 32'(bus.in_ready), 1);
    step(1); drv(1'b0, 19'h0); #1;
    cmp("br_class", 32'(bus.out_class), 32'b1000);
    cmp("br_rs", 32'(bus.out_rs), 2);
    cmp("br_rn", 32'(bus.out_rn), 3);
    cmp("br_imm", 32'(bus.out_imm), 32'hFFFE);
    cmp("br_writes", 32'(bus.out_writes_reg), 0);

    // Output hold under backpressure.
    drv(1'b1, 19'h07600); step(1);
    bus.out_ready = 1'b0; drv(1'b1, 19'h21000);
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp("hold_ready", 32'(bus.in_ready), 0);
      cmp("hold_opcode_rd", 32'({bus.out_opcode, bus.out_rd}), 32'({5'd1, 2'd3}));
      step(1);
    end
    bus.out_ready = 1'b1; #1; cmp("hold_release_ready", 32'(bus.in_ready), 1);
    step(1); drv(1'b0, 19'h0); #1;
    cmp("hold_next_opcode", 32'(bus.out_opcode), 8);
    wb(1'b1, 2'd1); step(1); wb(1'b1, 2'd3); step(1); wb(1'b0, 2'd0);

    // Flush squashes the bundle and its pending bit.
    bus.out_ready = 1'b0;
    drv(1'b1, 19'h0B00A); #1; cmp("fl_accept", 32'(bus.in_ready), 1);
    step(1); drv(1'b0, 19'h0); bus.flush = 1'b1; step(1); bus.flush = 1'b0;
    drv(1'b1, 19'h04C00); #1;
    cmp("fl_out_valid", 32'(bus.out_valid), 0);
    cmp("fl_r3_no_stall", 32'(bus.in_ready), 1);
    step(1); drv(1'b0, 19'h0); bus.out_ready = 1'b1; #1;
    cmp("fl_next_rs", 32'(bus.out_rs), 3);

    // Undefined opcode.
    drv(1'b1, 19'h7C000); #1; cmp("ill_accept", 32'(bus.in_ready), 1);
    step(1); drv(1'b1, 19'h21000); #1;
    cmp("ill_class", 32'(bus.out_class), 0);
    cmp("ill_writes", 32'(bus.out_writes_reg), 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    cmp("ill_flag", 32'(bus.out_illegal), 1);
    cmp("ill_halted", 32'(bus.in_ready), 0);
    step(2); #1; cmp("ill_halted_hold", 32'(bus.in_ready), 0);
    bus.flush = 1'b1; step(1); bus.flush = 1'b0; #1;
    cmp("ill_flush_release", 32'(bus.in_ready), 1);
    step(1);
`else
    cmp("ill_flag", 32'(bus.out_illegal), 0);
    cmp("ill_no_stall", 32'(bus.in_ready), 1);
    step(1);
`endif
    drv(1'b0, 19'h0); wb(1'b1, 2'd1); step(1); wb(1'b0, 2'd0);

    // Asynchronous reset during a stall.
    bus.out_ready = 1'b0;
    drv(1'b1, 19'h21000); #1; cmp("rs_accept", 32'(bus.in_ready), 1);
    step(1); #1; cmp("rs_stalled", 32'(bus.in_ready), 0);
    rst_n = 1'b0; #1;
    cmp("rs_out_valid", 32'(bus.out_valid), 0);
    cmp("rs_opcode", 32'(bus.out_opcode), 0);
    cmp("rs_ready", 32'(bus.in_ready), 0);
    step(1); rst_n = 1'b1; #1;
    cmp("rs_pending_cleared", 32'(bus.in_ready), 1);
    step(1); drv(1'b0, 19'h0); bus.out_ready = 1'b1;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
